// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-channel synchroniser, debounce FSM and counter,
// producing clean levels plus one-cycle rise/fall pulses for downstream logic.
`timescale 1ns/1ps

module switch_debouncer #(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            I_P_CLK,
    input  logic            I_P_RST,
    input  logic [N_CH-1:0] I_P_SW,
    output logic [N_CH-1:0] O_P_SW_DB,
    output logic [N_CH-1:0] O_P_SW_RISE,
    output logic [N_CH-1:0] O_P_SW_FALL,
    output logic [N_CH-1:0] O_P_BUSY
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;

        // Raw switch is asynchronous; only the last stage of this chain is ever read.
        always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
            if (I_P_RST) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], I_P_SW[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1];

        always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
            if (I_P_RST) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // A WAIT state accepts the candidate only after an unbroken run ending at
        // the terminal count; any contrary sample drops back and discards the count.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_d = WAIT_HI;
                        cnt_d   = '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_d = WAIT_LO;
                        cnt_d   = '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end
            endcase
        end

        // Debounced level is implied by the state, so it flips on the pulse edge.
        assign O_P_SW_DB[i]   = (state_q == STABLE_HI) || (state_q == WAIT_LO);
        assign O_P_BUSY[i]    = (state_q == WAIT_HI) || (state_q == WAIT_LO);
        assign O_P_SW_RISE[i] = rise_q;
        assign O_P_SW_FALL[i] = fall_q;
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a short debounce window; expected
// outputs are queued as each input is driven and compared one edge later.
`timescale 1ns/1ps

module tb_switch_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic [1:0] sw_db;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic [1:0] busy;

    int checks = 0;
    int passes = 0;

    typedef struct {
        string      tag;
        logic [1:0] db;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] busy;
    } exp_t;

    exp_t exp_q[$];

    switch_debouncer #(
        .N_CH           (2),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .I_P_CLK    (clk),
        .I_P_RST    (rst),
        .I_P_SW     (sw),
        .O_P_SW_DB  (sw_db),
        .O_P_SW_RISE(sw_rise),
        .O_P_SW_FALL(sw_fall),
        .O_P_BUSY   (busy)
    );

    always #5 clk = ~clk;

    task automatic push_expect(input string tag, input logic [1:0] db, input logic [1:0] rise,
                               input logic [1:0] fall, input logic [1:0] bsy);
        exp_t e;
        e.tag  = tag;
        e.db   = db;
        e.rise = rise;
        e.fall = fall;
        e.busy = bsy;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t       e;
        logic [7:0] obs;
        logic [7:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            $error("[TB] FAIL scoreboard_empty: observed 0 queued entries, expected at least 1");
            return;
        end
        e    = exp_q.pop_front();
        obs  = {sw_db, sw_rise, sw_fall, busy};
        want = {e.db, e.rise, e.fall, e.busy};
        assert (obs === want) passes++;
        else $error("[TB] FAIL %s: observed db=%b rise=%b fall=%b busy=%b, expected db=%b rise=%b fall=%b busy=%b",
                    e.tag, sw_db, sw_rise, sw_fall, busy, e.db, e.rise, e.fall, e.busy);
    endtask

    // Drive the switches for one edge, queue what must be seen after it, then check.
    task automatic apply_stimulus(input logic [1:0] sw_val, input string tag, input logic [1:0] db,
                                  input logic [1:0] rise, input logic [1:0] fall, input logic [1:0] bsy);
        sw = sw_val;
        push_expect(tag, db, rise, fall, bsy);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic run(input logic [1:0] sw_val, input int n, input string tag, input logic [1:0] db,
                       input logic [1:0] rise, input logic [1:0] fall, input logic [1:0] bsy);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(sw_val, tag, db, rise, fall, bsy);
        end
    endtask

    initial begin
        rst = 1'b1;
        sw  = 2'b00;
        #2;
        push_expect("reset_state", 2'b00, 2'b00, 2'b00, 2'b00);
        check_output();
        run(2'b00, 2, "reset_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;

        // Both switches high through release: a normal rise after the full latency.
        run(2'b11, 2, "rel_sync",  2'b00, 2'b00, 2'b00, 2'b00);
        run(2'b11, 4, "rel_busy",  2'b00, 2'b00, 2'b00, 2'b11);
        run(2'b11, 1, "rel_rise",  2'b11, 2'b11, 2'b00, 2'b00);
        run(2'b11, 1, "rel_after", 2'b11, 2'b00, 2'b00, 2'b00);

        // Asynchronous reset with both levels high clears outputs before any edge.
        rst = 1'b1;
        #1;
        push_expect("t1_async", 2'b00, 2'b00, 2'b00, 2'b00);
        check_output();
        run(2'b11, 3, "t1_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;

        run(2'b01, 2, "t2_sync",  2'b00, 2'b00, 2'b00, 2'b00);
        run(2'b01, 4, "t2_busy",  2'b00, 2'b00, 2'b00, 2'b01);
        run(2'b01, 1, "t2_rise",  2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 1, "t2_after", 2'b01, 2'b00, 2'b00, 2'b00);

        run(2'b00, 2, "lo_sync",  2'b01, 2'b00, 2'b00, 2'b00);
        run(2'b00, 4, "lo_busy",  2'b01, 2'b00, 2'b00, 2'b01);
        run(2'b00, 1, "lo_fall",  2'b00, 2'b00, 2'b01, 2'b00);
        run(2'b00, 1, "lo_after", 2'b00, 2'b00, 2'b00, 2'b00);

        // Three-cycle high excursion is too short and must be dropped silently.
        run(2'b01, 2, "t3_sync",  2'b00, 2'b00, 2'b00, 2'b00);
        run(2'b01, 1, "t3_wait",  2'b00, 2'b00, 2'b00, 2'b01);
        run(2'b00, 2, "t3_wait",  2'b00, 2'b00, 2'b00, 2'b01);
        run(2'b00, 3, "t3_abort", 2'b00, 2'b00, 2'b00, 2'b00);

        // Bounce 1,1,0,1,1,1,1 then held: one rise, counted from the final 0.
        apply_stimulus(2'b01, "t4_b0",    2'b00, 2'b00, 2'b00, 2'b00);
        apply_stimulus(2'b01, "t4_b1",    2'b00, 2'b00, 2'b00, 2'b00);
        apply_stimulus(2'b00, "t4_b2",    2'b00, 2'b00, 2'b00, 2'b01);
        apply_stimulus(2'b01, "t4_b3",    2'b00, 2'b00, 2'b00, 2'b01);
        apply_stimulus(2'b01, "t4_b4",    2'b00, 2'b00, 2'b00, 2'b00);
        apply_stimulus(2'b01, "t4_b5",    2'b00, 2'b00, 2'b00, 2'b01);
        apply_stimulus(2'b01, "t4_b6",    2'b00, 2'b00, 2'b00, 2'b01);
        apply_stimulus(2'b01, "t4_b7",    2'b00, 2'b00, 2'b00, 2'b01);
        apply_stimulus(2'b01, "t4_b8",    2'b00, 2'b00, 2'b00, 2'b01);
        apply_stimulus(2'b01, "t4_rise",  2'b01, 2'b01, 2'b00, 2'b00);
        apply_stimulus(2'b01, "t4_after", 2'b01, 2'b00, 2'b00, 2'b00);

        run(2'b10, 2, "x_sync",  2'b01, 2'b00, 2'b00, 2'b00);
        run(2'b10, 4, "x_busy",  2'b01, 2'b00, 2'b00, 2'b11);
        run(2'b10, 1, "x_swap",  2'b10, 2'b10, 2'b01, 2'b00);
        run(2'b10, 1, "x_after", 2'b10, 2'b00, 2'b00, 2'b00);

        // Opposite transitions on the two channels land on the same edge.
        run(2'b01, 2, "t5_sync",  2'b10, 2'b00, 2'b00, 2'b00);
        run(2'b01, 4, "t5_busy",  2'b10, 2'b00, 2'b00, 2'b11);
        run(2'b01, 1, "t5_swap",  2'b01, 2'b01, 2'b10, 2'b00);
        run(2'b01, 1, "t5_after", 2'b01, 2'b00, 2'b00, 2'b00);

        run(2'b00, 2, "lo2_sync",  2'b01, 2'b00, 2'b00, 2'b00);
        run(2'b00, 4, "lo2_busy",  2'b01, 2'b00, 2'b00, 2'b01);
        run(2'b00, 1, "lo2_fall",  2'b00, 2'b00, 2'b01, 2'b00);
        run(2'b00, 1, "lo2_after", 2'b00, 2'b00, 2'b00, 2'b00);

        // Reset lands mid-qualification; the partial count must not carry over.
        run(2'b01, 2, "t6_sync", 2'b00, 2'b00, 2'b00, 2'b00);
        run(2'b01, 3, "t6_cnt",  2'b00, 2'b00, 2'b00, 2'b01);
        rst = 1'b1;
        #1;
        push_expect("t6_async", 2'b00, 2'b00, 2'b00, 2'b00);
        check_output();
        run(2'b01, 1, "t6_hold", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        run(2'b01, 2, "t6_resync", 2'b00, 2'b00, 2'b00, 2'b00);
        run(2'b01, 4, "t6_busy",   2'b00, 2'b00, 2'b00, 2'b01);
        run(2'b01, 1, "t6_rise",   2'b01, 2'b01, 2'b00, 2'b00);
        run(2'b01, 1, "t6_after",  2'b01, 2'b00, 2'b00, 2'b00);

        if (exp_q.size() != 0) begin
            checks++;
            $error("[TB] FAIL scoreboard_leftover: observed %0d unchecked entries, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
